// File: rtl/mdbrot_pkg.sv
// mdbrot_pkg: shared screen geometry, pixel types and frame-store state enum
package mdbrot_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int CW = 3;
  localparam int FB_DEPTH = 19200;
  typedef logic [7:0] pix_x_t;
  typedef logic [6:0] pix_y_t;
  typedef logic [CW-1:0] colour_t;
  typedef logic [14:0] fb_addr_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fs_state_t;
  function automatic fb_addr_t xy_to_addr(input pix_x_t x, input pix_y_t y);
    return fb_addr_t'({y, 7'b0}) + fb_addr_t'({y, 5'b0}) + fb_addr_t'(x);
  endfunction
endpackage

// File: rtl/mdbrot_fb_ram.sv
// mdbrot_fb_ram: simple dual-port frame buffer, one write port, registered read port
module mdbrot_fb_ram
  import mdbrot_pkg::*;
(
  input  logic     clk,
  input  logic     we,
  input  fb_addr_t wr_addr,
  input  colour_t  wr_data,
  input  fb_addr_t rd_addr,
  output colour_t  rd_data
);
  colour_t mem [FB_DEPTH];
  // write port and one-cycle-latency read port, no reset on contents
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/mdbrot_frame_store.sv
// mdbrot_frame_store: captures the plot stream into a frame buffer and replays it in raster order
module mdbrot_frame_store
  import mdbrot_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [2:0]  in_colour,
  input  logic        in_plot,
  input  logic        replay,
  output logic [7:0]  out_x,
  output logic [6:0]  out_y,
  output logic [2:0]  out_colour,
  output logic        out_plot,
  output logic        busy,
  output logic        frame_done,
  output logic [14:0] pix_count,
  output logic        dropped
);
  fs_state_t state_q, state_d;
  logic replay_q, replay_d, arm_q, arm_d;
  pix_x_t rx_q, rx_d, x1_q, x1_d, out_x_q, out_x_d;
  pix_y_t ry_q, ry_d, y1_q, y1_d, out_y_q, out_y_d;
  colour_t out_colour_q, out_colour_d, rd_data;
  logic v1_q, v1_d, out_plot_q, out_plot_d, busy_q, busy_d;
  logic fd_q, fd_d, dropped_q, dropped_d;
  fb_addr_t pix_q, pix_d;
  logic rise, start, accept, last;

  mdbrot_fb_ram u_ram (
    .clk     (CLOCK_50),
    .we      (accept),
    .wr_addr (xy_to_addr(in_x, in_y)),
    .wr_data (in_colour),
    .rd_addr (xy_to_addr(rx_q, ry_q)),
    .rd_data (rd_data)
  );

  // replay sequencing, read pipeline alignment and capture bookkeeping
  always_comb begin
    rise = replay & ~replay_q & arm_q;
    start = rise & ~busy_q;
    accept = in_plot & ~busy_q & (in_x < 8'(SCREEN_W)) & (in_y < 7'(SCREEN_H));
    last = (rx_q == 8'(SCREEN_W - 1)) && (ry_q == 7'(SCREEN_H - 1));
    replay_d = replay;
    arm_d = arm_q | ~replay;
    state_d = state_q;
    rx_d = rx_q;
    ry_d = ry_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        rx_d = '0;
        ry_d = '0;
      end
      RUN: if (last) state_d = DRAIN;
        else if (rx_q == 8'(SCREEN_W - 1)) begin
          rx_d = '0;
          ry_d = ry_q + 7'd1;
        end else rx_d = rx_q + 8'd1;
      default: state_d = IDLE;
    endcase
    v1_d = state_q == RUN;
    x1_d = rx_q;
    y1_d = ry_q;
    out_plot_d = v1_q;
    out_x_d = v1_q ? x1_q : out_x_q;
    out_y_d = v1_q ? y1_q : out_y_q;
    out_colour_d = v1_q ? rd_data : out_colour_q;
    busy_d = start | (busy_q & ~(out_plot_q & ~v1_q));
    fd_d = start ? 1'b0 : (accept && in_x == 8'(SCREEN_W - 1) && in_y == 7'(SCREEN_H - 1)) ? 1'b1 : fd_q;
    pix_d = start ? '0 : (accept && pix_q != fb_addr_t'(FB_DEPTH)) ? pix_q + 15'd1 : pix_q;
    dropped_d = dropped_q | (in_plot & busy_q);
  end

  // state and output registers, all cleared by the asynchronous reset
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      replay_q <= 1'b0;
      arm_q <= 1'b0;
      rx_q <= '0;
      ry_q <= '0;
      v1_q <= 1'b0;
      x1_q <= '0;
      y1_q <= '0;
      out_plot_q <= 1'b0;
      out_x_q <= '0;
      out_y_q <= '0;
      out_colour_q <= '0;
      busy_q <= 1'b0;
      fd_q <= 1'b0;
      pix_q <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      replay_q <= replay_d;
      arm_q <= arm_d;
      rx_q <= rx_d;
      ry_q <= ry_d;
      v1_q <= v1_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
      out_plot_q <= out_plot_d;
      out_x_q <= out_x_d;
      out_y_q <= out_y_d;
      out_colour_q <= out_colour_d;
      busy_q <= busy_d;
      fd_q <= fd_d;
      pix_q <= pix_d;
      dropped_q <= dropped_d;
    end
  end

  assign out_x = out_x_q;
  assign out_y = out_y_q;
  assign out_colour = out_colour_q;
  assign out_plot = out_plot_q;
  assign busy = busy_q;
  assign frame_done = fd_q;
  assign pix_count = pix_q;
  assign dropped = dropped_q;
endmodule
